// File: rtl/demux_buf_pkg.sv
// Shared constants for the demux_buf 1-to-2 stream demultiplexer:
// select encodings, default geometry and the stats counter helper.
package demux_buf_pkg;

    localparam logic CH1_SEL   = 1'b1;
    localparam logic CH2_SEL   = 1'b0;
    localparam int   DEF_WIDTH = 1;
    localparam int   DEF_DEPTH = 4;
    localparam int   STATS_W   = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Per-channel synchronous FIFO with a registered head-of-queue output that
// shows a freshly pushed word immediately after the push edge.
module demux_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push, pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign rd_nxt  = rd_ptr_q + PTR_W'(1);
    assign dout_o  = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_nxt;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The incoming word becomes the head when the queue is, or is about to be, empty.
        if (push && (empty_o || (pop && count_q == CNT_W'(1))))
            dout_d = din_i;
        else if (pop && count_q > CNT_W'(1))
            dout_d = mem_q[rd_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            if (push) mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/demux_buf.sv
// Registered 1-to-2 stream demultiplexer: steers Din into one of two FIFOs by Sel.
// Define DEMUX_BUF_STATS_EN to add the cnt1/cnt2/stall statistics outputs.
module demux_buf
    import demux_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   Din,
    input  logic               Sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   Dout1,
    output logic               Dout1_valid,
    input  logic               Dout1_ready,
    output logic [WIDTH-1:0]   Dout2,
    output logic               Dout2_valid,
    input  logic               Dout2_ready
`ifdef DEMUX_BUF_STATS_EN
    ,
    output logic [STATS_W-1:0] cnt1,
    output logic [STATS_W-1:0] cnt2,
    output logic               stall
`endif
);

    logic full1, full2, empty1, empty2;
    logic accept, push1, push2;

    // Only the addressed channel's fullness matters; no pop-side bypass.
    assign in_ready    = !rst && !((Sel == CH1_SEL) ? full1 : full2);
    assign accept      = in_valid && in_ready;
    assign push1       = accept && (Sel == CH1_SEL);
    assign push2       = accept && (Sel == CH2_SEL);
    assign Dout1_valid = !empty1;
    assign Dout2_valid = !empty2;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push1),
        .din_i   (Din),
        .pop_i   (Dout1_ready),
        .dout_o  (Dout1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push2),
        .din_i   (Din),
        .pop_i   (Dout2_ready),
        .dout_o  (Dout2),
        .full_o  (full2),
        .empty_o (empty2)
    );

`ifdef DEMUX_BUF_STATS_EN
    logic [STATS_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic               stall_q, stall_d;

    always_comb begin
        cnt1_d  = push1 ? sat_inc(cnt1_q) : cnt1_q;
        cnt2_d  = push2 ? sat_inc(cnt2_q) : cnt2_q;
        stall_d = in_valid && !in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            stall_q <= stall_d;
        end
    end

    assign cnt1  = cnt1_q;
    assign cnt2  = cnt2_q;
    assign stall = stall_q;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf (WIDTH=8, DEPTH=4); stats checks run when
// DEMUX_BUF_STATS_EN is defined.
module tb_demux_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Din;
    logic       Sel, in_valid, in_ready;
    logic [7:0] Dout1, Dout2;
    logic       Dout1_valid, Dout1_ready, Dout2_valid, Dout2_ready;
`ifdef DEMUX_BUF_STATS_EN
    logic [15:0] cnt1, cnt2;
    logic        stall;
    int          stall_n = 0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    demux_buf #(.WIDTH(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .Din         (Din),
        .Sel         (Sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Dout1       (Dout1),
        .Dout1_valid (Dout1_valid),
        .Dout1_ready (Dout1_ready),
        .Dout2       (Dout2),
        .Dout2_valid (Dout2_valid),
        .Dout2_ready (Dout2_ready)
`ifdef DEMUX_BUF_STATS_EN
        ,
        .cnt1        (cnt1),
        .cnt2        (cnt2),
        .stall       (stall)
`endif
    );

`ifdef DEMUX_BUF_STATS_EN
    always @(negedge clk) if (stall === 1'b1) stall_n++;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic s, input logic v,
                         input logic r1, input logic r2);
        Din = d; Sel = s; in_valid = v; Dout1_ready = r1; Dout2_ready = r2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] w;
        int         sent;
        logic       exp_rdy;

        rst = 1'b1;
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_d1v", 32'(Dout1_valid), 0);
        chk("rst_d2v", 32'(Dout2_valid), 0);
        chk("rst_dout1", 32'(Dout1), 0);
        chk("rst_dout2", 32'(Dout2), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);

        // steering with both consumers ready
        drive(8'd1, 1'b1, 1'b1, 1'b1, 1'b1); step();
        chk("steer_d1_a", 32'(Dout1), 1);
        chk("steer_d1v_a", 32'(Dout1_valid), 1);
        drive(8'd1, 1'b0, 1'b1, 1'b1, 1'b1); step();
        chk("steer_d2", 32'(Dout2), 1);
        chk("steer_d2v", 32'(Dout2_valid), 1);
        chk("steer_d1v_pop", 32'(Dout1_valid), 0);
        drive(8'd0, 1'b1, 1'b1, 1'b1, 1'b1); step();
        chk("steer_d1_b", 32'(Dout1), 0);
        chk("steer_d1v_b", 32'(Dout1_valid), 1);
        chk("steer_d2v_pop", 32'(Dout2_valid), 0);
        drive(8'd0, 1'b1, 1'b0, 1'b1, 1'b1); step();
        chk("steer_d1v_end", 32'(Dout1_valid), 0);
        chk("steer_d1_hold", 32'(Dout1), 0);

        // fill channel 1, check backpressure is per channel
        for (int i = 0; i < 4; i++) begin
            w = 8'(8'h11 * (i + 1));
            drive(w, 1'b1, 1'b1, 1'b0, 1'b0); step();
        end
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("full_rdy_sel1", 32'(in_ready), 0);
        Sel = 1'b0; #1;
        chk("full_rdy_sel0", 32'(in_ready), 1);
        chk("full_head", 32'(Dout1), 'h11);
        drive(8'h55, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("ch2_push_55", 32'(Dout2), 'h55);
        chk("ch2_v_55", 32'(Dout2_valid), 1);
        drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b1); #1;
        chk("no_bypass", 32'(in_ready), 0);
        step(); chk("drain_22", 32'(Dout1), 'h22);
        chk("ch2_drained", 32'(Dout2_valid), 0);
        step(); chk("drain_33", 32'(Dout1), 'h33);
        step(); chk("drain_44", 32'(Dout1), 'h44);
        step(); chk("drain_empty", 32'(Dout1_valid), 0);
        chk("drain_hold", 32'(Dout1), 'h44);

        // wrap-around on channel 2 with toggling ready
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            if (sent == 10 && q.size() == 0) break;
            w = 8'(8'hA0 + sent);
            drive(w, 1'b0, sent < 10, 1'b0, c[0]);
            #1;
            exp_rdy = (q.size() < 4);
            chk("wrap_rdy", 32'(in_ready), 32'(exp_rdy));
            chk("wrap_valid", 32'(Dout2_valid), 32'(q.size() != 0));
            if (Dout2_ready && q.size() != 0) chk("wrap_data", 32'(Dout2), 32'(q.pop_front()));
            if (in_valid && exp_rdy) begin
                q.push_back(w);
                sent++;
            end
            @(posedge clk); #1;
        end
        chk("wrap_done_sent", sent, 10);
        chk("wrap_done_empty", q.size(), 0);

        // simultaneous push and pop at count 3 on channel 1
        for (int i = 0; i < 3; i++) begin
            w = 8'(8'h61 + i);
            drive(w, 1'b1, 1'b1, 1'b0, 1'b0); step();
        end
        drive(8'h64, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        chk("pp_rdy", 32'(in_ready), 1);
        chk("pp_head", 32'(Dout1), 'h61);
        step(); chk("pp_62", 32'(Dout1), 'h62);
        drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        chk("pp_cnt3", 32'(in_ready), 1);
        step(); chk("pp_63", 32'(Dout1), 'h63);
        step(); chk("pp_64", 32'(Dout1), 'h64);
        step(); chk("pp_empty", 32'(Dout1_valid), 0);

        // asynchronous reset with 3 words buffered and a push in flight
        for (int i = 0; i < 3; i++) begin
            w = 8'(8'h71 + i);
            drive(w, 1'b1, 1'b1, 1'b0, 1'b0); step();
        end
        drive(8'h74, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        rst = 1'b1; #1;
        chk("mrst_in_ready", 32'(in_ready), 0);
        chk("mrst_d1v", 32'(Dout1_valid), 0);
        chk("mrst_d2v", 32'(Dout2_valid), 0);
        chk("mrst_dout1", 32'(Dout1), 0);
        chk("mrst_dout2", 32'(Dout2), 0);
        step();
        rst = 1'b0;
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("mrel_in_ready", 32'(in_ready), 1);
        chk("mrel_d1v", 32'(Dout1_valid), 0);
        step();
        chk("mrel_d1v_idle", 32'(Dout1_valid), 0);
        drive(8'h75, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("mrel_push", 32'(Dout1), 'h75);
        chk("mrel_push_v", 32'(Dout1_valid), 1);

`ifdef DEMUX_BUF_STATS_EN
        rst = 1'b1; #1;
        chk("st_rst_cnt1", 32'(cnt1), 0);
        chk("st_rst_cnt2", 32'(cnt2), 0);
        step();
        rst = 1'b0;
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0); step();
        stall_n = 0;
        for (int i = 0; i < 4; i++) begin
            w = 8'(8'h91 + i);
            drive(w, 1'b1, 1'b1, 1'b0, 1'b0); step();
        end
        chk("st_stall_before", 32'(stall), 0);
        drive(8'h99, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("st_stall_pulse", 32'(stall), 1);
        drive(8'h81, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("st_stall_clear", 32'(stall), 0);
        drive(8'h82, 1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b0); step();
        drive(8'h95, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0); step(); step();
        chk("st_cnt1", 32'(cnt1), 5);
        chk("st_cnt2", 32'(cnt2), 2);
        chk("st_stall_n", stall_n, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
